// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down modulo counter.
// Direction and boundary-mode encodings match the raw up_dn/sat pins.
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   typedef enum logic {
      BM_WRAP = 1'b0,
      BM_SAT  = 1'b1
   } bmode_e;

   localparam int DEFAULT_CNT_WIDTH = 8;

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulo counter.
// master drives the controls, slave is the counter itself.
interface updown_mod_counter_if
   import counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_CNT_WIDTH
);

   logic             en;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             up_dn;
   logic             sat;
   logic [WIDTH-1:0] mod_max;
   logic             ovf_clr;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             ovf;

   modport master (
      output en, clr, load, load_val,
      output up_dn, sat, mod_max, ovf_clr,
      input  out, tc, ovf
   );

   modport slave (
      input  en, clr, load, load_val,
      input  up_dn, sat, mod_max, ovf_clr,
      output out, tc, ovf
   );

endinterface

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE into a single-cycle tick.
// Phase only moves while en=1; sync_clr restarts a full period.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (sync_clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..mod_max with wrap/saturate, prescaled steps,
// a one-cycle terminal-count pulse and a sticky boundary flag.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_CNT_WIDTH,
   parameter int PRESCALE = 1
) (
   input logic                 clk,
   input logic                 rst,
   updown_mod_counter_if.slave bus
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] nxt;
   logic             tc_q;
   logic             ovf_q;
   logic             tick;
   logic             hit;
   logic             step;
   dir_e             dir;
   bmode_e           mode;

   assign dir  = dir_e'(bus.up_dn);
   assign mode = bmode_e'(bus.sat);

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_presc (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .sync_clr (bus.clr | bus.load),
      .tick     (tick)
   );

   assign step = bus.en && tick && !bus.clr && !bus.load;

   // A loaded value above mod_max counts as a terminal case going up.
   always_comb begin
      nxt = cnt_q;
      hit = 1'b0;
      unique case (dir)
         DIR_UP: begin
            if (cnt_q < bus.mod_max) begin
               nxt = cnt_q + WIDTH'(1);
            end else begin
               hit = 1'b1;
               nxt = (mode == BM_SAT) ? bus.mod_max : '0;
            end
         end
         DIR_DOWN: begin
            if (cnt_q != '0) begin
               nxt = cnt_q - WIDTH'(1);
            end else begin
               hit = 1'b1;
               nxt = (mode == BM_SAT) ? '0 : bus.mod_max;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else if (bus.clr) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else if (bus.load) begin
         cnt_q <= bus.load_val;
         tc_q  <= 1'b0;
      end else if (step) begin
         cnt_q <= nxt;
         tc_q  <= hit;
      end else begin
         tc_q  <= 1'b0;
      end
   end

   // A boundary step wins over a coincident ovf_clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (step && hit) begin
         ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign bus.out = cnt_q;
   assign bus.tc  = tc_q;
   assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench: two counters (PRESCALE 1 and 3) against an arithmetic model.
// Directed scenarios first, then randomized controls.
module tb_updown_mod_counter;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   logic         en, clr, load, up_dn, sat, ovf_clr;
   logic [W-1:0] load_val, mod_max;

   updown_mod_counter_if #(.WIDTH(W)) b1 ();
   updown_mod_counter_if #(.WIDTH(W)) b3 ();

   assign b1.en = en;        assign b3.en = en;
   assign b1.clr = clr;      assign b3.clr = clr;
   assign b1.load = load;    assign b3.load = load;
   assign b1.load_val = load_val;
   assign b3.load_val = load_val;
   assign b1.up_dn = up_dn;  assign b3.up_dn = up_dn;
   assign b1.sat = sat;      assign b3.sat = sat;
   assign b1.mod_max = mod_max;
   assign b3.mod_max = mod_max;
   assign b1.ovf_clr = ovf_clr;
   assign b3.ovf_clr = ovf_clr;

   updown_mod_counter #(.WIDTH(W), .PRESCALE(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   updown_mod_counter #(.WIDTH(W), .PRESCALE(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b3.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int m_out [2];
   int m_tc  [2];
   int m_ovf [2];
   int m_ph  [2];
   int presc [2] = '{1, 3};

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_out[i] = 0;
         m_tc[i]  = 0;
         m_ovf[i] = 0;
         m_ph[i]  = 0;
      end
   endtask

   // One rising edge of counter i, straight from the behavioural rules.
   task automatic model_step(input int i);
      int mm;
      int hit;
      mm  = int'(mod_max);
      hit = 0;
      m_tc[i] = 0;
      if (clr) begin
         m_out[i] = 0;
         m_ph[i]  = 0;
      end else if (load) begin
         m_out[i] = int'(load_val);
         m_ph[i]  = 0;
      end else if (en) begin
         m_ph[i] = m_ph[i] + 1;
         if (m_ph[i] == presc[i]) begin
            m_ph[i] = 0;
            if (up_dn) begin
               if (m_out[i] < mm) m_out[i] = m_out[i] + 1;
               else begin
                  hit = 1;
                  m_out[i] = sat ? mm : 0;
               end
            end else begin
               if (m_out[i] > 0) m_out[i] = m_out[i] - 1;
               else begin
                  hit = 1;
                  m_out[i] = sat ? 0 : mm;
               end
            end
            m_tc[i] = hit;
         end
      end
      if (hit != 0) m_ovf[i] = 1;
      else if (ovf_clr) m_ovf[i] = 0;
   endtask

   task automatic compare_all();
      check("out1", 32'(b1.out), m_out[0]);
      check("tc1",  32'(b1.tc),  m_tc[0]);
      check("ovf1", 32'(b1.ovf), m_ovf[0]);
      check("out3", 32'(b3.out), m_out[1]);
      check("tc3",  32'(b3.tc),  m_tc[1]);
      check("ovf3", 32'(b3.ovf), m_ovf[1]);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tcs;
      en = 0; clr = 0; load = 0; load_val = '0;
      up_dn = 1; sat = 0; mod_max = 4'd9; ovf_clr = 0;
      model_reset();
      #12;
      compare_all();
      rst = 1'b1;

      // up/wrap through mod_max=9
      en = 1;
      for (int k = 1; k <= 11; k++) begin
         cycle();
         check("wrap_out", 32'(b1.out), k % 10);
         check("wrap_tc", 32'(b1.tc), (k == 10) ? 1 : 0);
         check("wrap_ovf", 32'(b1.ovf), (k >= 10) ? 1 : 0);
      end

      // down/saturate from 2
      en = 0; load = 1; load_val = 4'd2; ovf_clr = 1;
      up_dn = 0; sat = 1;
      cycle();
      check("sat_load", 32'(b1.out), 2);
      load = 0; ovf_clr = 0; en = 1;
      tcs = 0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         tcs += int'(b1.tc);
      end
      check("sat_out", 32'(b1.out), 0);
      check("sat_tcs", 32'(tcs), 2);
      check("sat_ovf", 32'(b1.ovf), 1);
      en = 0; ovf_clr = 1;
      cycle();
      check("ovf_clr", 32'(b1.ovf), 0);
      ovf_clr = 0;

      // clr beats load beats step
      clr = 1; load = 1; load_val = 4'd7; en = 1;
      cycle();
      check("prio_clr", 32'(b1.out), 0);
      clr = 0;
      cycle();
      check("prio_load", 32'(b1.out), 7);
      load = 0;

      // prescale 3 with an en gap
      en = 0; clr = 1; up_dn = 1; sat = 0;
      cycle();
      clr = 0;
      for (int k = 0; k < 10; k++) begin
         en = (k != 5);
         cycle();
         if (k == 5) check("gap_hold", 32'(b3.out), 1);
      end
      check("presc_out", 32'(b3.out), 3);

      // out-of-range load, then wrap both ways
      en = 0; load = 1; load_val = 4'd12;
      cycle();
      check("big_load", 32'(b1.out), 12);
      load = 0; en = 1;
      cycle();
      check("big_wrap", 32'(b1.out), 0);
      check("big_tc", 32'(b1.tc), 1);
      up_dn = 0;
      cycle();
      check("dn_wrap", 32'(b1.out), 9);

      // asynchronous reset between edges
      en = 0; clr = 1;
      cycle();
      clr = 0; en = 1; up_dn = 1;
      repeat (5) cycle();
      check("pre_rst", 32'(b1.out), 5);
      #2 rst = 1'b0;
      #1;
      check("arst_out", 32'(b1.out), 0);
      check("arst_tc", 32'(b1.tc), 0);
      check("arst_ovf", 32'(b1.ovf), 0);
      check("arst_out3", 32'(b3.out), 0);
      model_reset();
      #3 rst = 1'b1;
      cycle();
      check("post_rst", 32'(b1.out), 1);
      cycle();
      cycle();
      check("post_rst3", 32'(b3.out), 1);

      // randomized controls
      for (int k = 0; k < 600; k++) begin
         en       = ($urandom % 4) != 0;
         clr      = ($urandom % 32) == 0;
         load     = ($urandom % 20) == 0;
         load_val = W'($urandom);
         ovf_clr  = ($urandom % 8) == 0;
         if ($urandom % 12 == 0) up_dn = ~up_dn;
         if ($urandom % 16 == 0) sat = ~sat;
         if ($urandom % 24 == 0) mod_max = W'($urandom);
         if (k == 300) begin
            #2 rst = 1'b0;
            #1 model_reset();
            #2 rst = 1'b1;
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
